// File: rtl/svo_busif.sv
`default_nettype none
// ============================================================================
//  Module   : svo_busif
//  Purpose  : Z80 bus interface for the text video card. Synchronises the
//             asynchronous Z80 strobes onto the pixel clock, holds the cursor
//             (X/Y) and attribute registers, and turns DATA / CLEAR writes
//             into a 29-bit command stream buffered in a small FIFO.
//  Ports    : clk, reset          pixel clock, async active-high reset
//             ncs, nwr, nrd       Z80 strobes (active-low, asynchronous)
//             addr, data_in       Z80 register address / write data
//             data_out, data_oe   read data and bus-drive enable
//             cmd_tvalid/tready/tdata  command stream
//                                 {clr, y[4:0], x[6:0], attr[7:0], char[7:0]}
//             fifo_full           command FIFO holds FIFO_DEPTH entries
//  Options  : SVO_BUSIF_AUTOINC_EN - DATA writes advance the cursor
//  Revision : 1.0  initial release
// ============================================================================
module svo_busif #(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ncs,
   input  logic        nwr,
   input  logic        nrd,
   input  logic [3:0]  addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        cmd_tvalid,
   input  logic        cmd_tready,
   output logic [28:0] cmd_tdata,
   output logic        fifo_full
);

   localparam int         c_AW   = $clog2(FIFO_DEPTH);
   localparam logic [6:0] c_XMAX = 7'(COLS - 1);
   localparam logic [4:0] c_YMAX = 5'(ROWS - 1);

   // ---------------------------------------------------------------- sync
   logic [1:0] r_ncs_s, r_nwr_s, r_nrd_s;
   logic [3:0] r_addr;
   logic [7:0] r_din;
   logic       r_wr_act_d, r_rd_act_d;
   logic       w_wr_act, w_rd_act, w_wr_pulse, w_rd_pulse;

   // Synchronisers reset to the idle (high) level so a strobe already low
   // when reset releases is seen as a fresh assertion, never a stale one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ncs_s    <= 2'b11;
         r_nwr_s    <= 2'b11;
         r_nrd_s    <= 2'b11;
         r_addr     <= 4'd0;
         r_din      <= 8'd0;
         r_wr_act_d <= 1'b0;
         r_rd_act_d <= 1'b0;
      end else begin
         r_ncs_s    <= {r_ncs_s[0], ncs};
         r_nwr_s    <= {r_nwr_s[0], nwr};
         r_nrd_s    <= {r_nrd_s[0], nrd};
         r_addr     <= addr;
         r_din      <= data_in;
         r_wr_act_d <= w_wr_act;
         r_rd_act_d <= w_rd_act;
      end
   end

   assign w_wr_act   = ~r_ncs_s[1] & ~r_nwr_s[1];
   assign w_rd_act   = ~r_ncs_s[1] & ~r_nrd_s[1];
   assign w_wr_pulse = w_wr_act & ~r_wr_act_d;
   assign w_rd_pulse = w_rd_act & ~r_rd_act_d;

   // ---------------------------------------------------------------- FIFO
   logic [28:0]   r_mem [FIFO_DEPTH];
   logic [c_AW:0] r_wptr, r_rptr;
   logic          w_full, w_empty, w_push_req, w_push, w_pop;
   logic [28:0]   w_push_data;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   // Full is judged on the current occupancy only: a same-cycle pop does
   // not make room for the push.
   assign w_push  = w_push_req & ~w_full;
   assign w_pop   = ~w_empty & cmd_tready;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr[c_AW-1:0]] <= w_push_data;
   end

   assign cmd_tvalid = ~w_empty;
   assign cmd_tdata  = r_mem[r_rptr[c_AW-1:0]];
   assign fifo_full  = w_full;

   // ------------------------------------------------------- write decode
   logic [6:0] r_x;
   logic [4:0] r_y;
   logic [7:0] r_attr;
   logic       r_overflow;
   logic [6:0] w_x_wr;
   logic [4:0] w_y_wr;
   logic [7:0] w_rd_mux;

   assign w_x_wr = (32'(r_din[6:0]) >= COLS) ? c_XMAX : r_din[6:0];
   assign w_y_wr = (32'(r_din[4:0]) >= ROWS) ? c_YMAX : r_din[4:0];

   always_comb begin
      w_push_req  = 1'b0;
      w_push_data = '0;
      if (w_wr_pulse) begin
         case (r_addr)
            4'd3: begin
               w_push_req  = 1'b1;
               w_push_data = {1'b0, r_y, r_x, r_attr, r_din};
            end
            4'd4: begin
               if (r_din[0]) begin
                  w_push_req  = 1'b1;
                  w_push_data = {1'b1, 5'd0, 7'd0, r_attr, 8'h20};
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (r_addr)
         4'd2:    w_rd_mux = r_attr;
         4'd5:    w_rd_mux = {4'b0, 1'b0, r_overflow, w_empty, w_full};
         4'd6:    w_rd_mux = {1'b0, r_x};
         4'd7:    w_rd_mux = {3'b0, r_y};
         default: w_rd_mux = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x        <= 7'd0;
         r_y        <= 5'd0;
         r_attr     <= 8'h0F;
         r_overflow <= 1'b0;
         data_out   <= 8'h00;
         data_oe    <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_wr_pulse) begin
            case (r_addr)
               4'd0: r_x    <= w_x_wr;
               4'd1: r_y    <= w_y_wr;
               4'd2: r_attr <= r_din;
               4'd3: begin
`ifdef SVO_BUSIF_AUTOINC_EN
                  // Cursor advances whether or not the push was accepted.
                  if (r_x == c_XMAX) begin
                     r_x <= 7'd0;
                     r_y <= (r_y == c_YMAX) ? 5'd0 : r_y + 5'd1;
                  end else begin
                     r_x <= r_x + 7'd1;
                  end
`endif
               end
               4'd4: begin
                  if (r_din[0]) begin
                     r_x <= 7'd0;
                     r_y <= 5'd0;
                  end
               end
               default: ;
            endcase
         end

         // STATUS read returns the old overflow bit (captured via the mux
         // this cycle) and clears it; a simultaneous drop re-sets it.
         if (w_rd_pulse && r_addr == 4'd5)
            r_overflow <= 1'b0;
         if (w_push_req && w_full)
            r_overflow <= 1'b1;

         if (w_rd_pulse)
            data_out <= w_rd_mux;
         data_oe <= w_rd_act;

         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/svo_busif.md
# svo_busif

Z80 bus interface for the video card, sitting directly upstream of the HDMI output stage on the pixel clock. Samples the asynchronous Z80 strobes (`ncs`, `nwr`, `nrd`, `addr`, `data`), maintains cursor and attribute registers, and turns character and clear writes into a 29-bit command stream. The text-card renderer consumes that stream to update its character RAM. CPU-visible status (FIFO full, FIFO empty, overflow, cursor) is returned on reads.

## Interface
Parameters:
- `COLS`, 80, columns; cursor X wraps at this value.
- `ROWS`, 30, rows; cursor Y wraps at this value.
- `FIFO_DEPTH`, 16, command FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ncs`, `nwr`, `nrd`  in  1 each  Z80 chip-select, write and read strobes; active-low, asynchronous to `clk`.
- `addr`  in  4  Z80 register address.
- `data_in`  in  8  Z80 write data.
- `data_out`  out  8  read data.
- `data_oe`  out  1  high while the top level must drive `data_out` onto the bus.
- `cmd_tvalid`  out  1  command available.
- `cmd_tready`  in  1  consumer accepts the command.
- `cmd_tdata`  out  29  command word, packed {clr, y[4:0], x[6:0], attr[7:0], char[7:0]}.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.

## Operation
- Strobe sync: `ncs`, `nwr`, `nrd` each pass through a 2-FF synchronizer. `addr` and `data_in` pass through one register stage.
- Write event: a one-cycle `wr_pulse` fires on the first cycle where synced (`~ncs & ~nwr`) is true after being false the previous cycle.
- Read event: a one-cycle `rd_pulse` fires the same way for synced (`~ncs & ~nrd`).
- Write registers, decoded on `wr_pulse`:
  - 0: X <= `data_in[6:0]`; values ≥ COLS are clamped to COLS-1.
  - 1: Y <= `data_in[4:0]`; values ≥ ROWS are clamped to ROWS-1.
  - 2: ATTR <= `data_in`.
  - 3: DATA. Pushes {0, Y, X, ATTR, `data_in`}, then advances the cursor (see Configuration).
  - 4: CTRL. Bit 0 = 1 pushes a clear command {1, 0, 0, ATTR, 0x20} and sets X = Y = 0.
  - 5–15: write ignored.
- Read registers:
  - 5: STATUS = {4'b0, 1'b0, overflow, empty, full}.
  - 6: X.
  - 7: Y.
  - 2: ATTR.
  - All other addresses read 0xFF.
- Read data: `data_out` is loaded from the read mux on `rd_pulse` and held until the next `rd_pulse`.
- Overflow clear: reading STATUS clears `overflow` in the same cycle. The value returned still shows the old bit.
- Bus drive: `data_oe` = synced (`~ncs & ~nrd`), registered.
- FIFO:
  - Synchronous, `FIFO_DEPTH` entries, with wrapping read/write pointers plus one extra bit for full/empty.
  - Pop occurs when `cmd_tvalid & cmd_tready`.
  - Push is dropped when the FIFO is full at the push cycle, even if a pop happens in the same cycle. A dropped push sets `overflow`.
  - When a DATA write is dropped, the cursor still advances.
  - When a CTRL clear is dropped, the cursor is still reset.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.

## Timing
- Reset values: `data_out` = 0x00, `data_oe` = 0, `cmd_tvalid` = 0, `fifo_full` = 0, X = Y = 0, ATTR = 0x0F, `overflow` = 0, FIFO empty.
- Reset asserted mid-transfer discards FIFO contents and any pending pulse.
- Latency from `nwr` falling to `wr_pulse`: 2–3 `clk` cycles.
- A push on `wr_pulse` cycle T makes `cmd_tvalid` = 1 at T+1. The FIFO has no fall-through.
- `cmd_tdata` is stable while `cmd_tvalid & ~cmd_tready`.
- Bus requirement: Z80 strobe-low time ≥ 4 `clk` periods, and `addr`/`data_in` stable throughout the strobe. A 25 MHz pixel clock against a ≤8 MHz Z80 satisfies this.
- One event per strobe assertion: a held strobe does not repeat the pulse.

## Configuration
- `SVO_BUSIF_AUTOINC_EN` defined: after a DATA push, X increments. At COLS-1, X wraps to 0 and Y increments. At ROWS-1, Y wraps to 0.
- Macro undefined: X and Y are unchanged by DATA writes; only registers 0, 1 and 4 modify them.

## Test plan
- Reset, with macro defined, `cmd_tready` = 1:
  - Write X = 5, Y = 2, ATTR = 0x1E, DATA = 0x41.
  - Required: exactly one command {0, 2, 5, 0x1E, 0x41}; reading X returns 6.
- Cursor wrap, macro defined: X = 79, Y = 29, then DATA = 0x42.
  - Required: command carries x = 79, y = 29; X and Y then read 0 and 0.
- Overflow, `cmd_tready` = 0: 17 DATA writes.
  - Required: `fifo_full` = 1 after the 16th.
  - STATUS read returns 0x05; a second STATUS read returns 0x01.
  - Draining returns the first 16 chars in order.
- Clear: ATTR = 0x70, CTRL = 0x01.
  - Required: command {1, 0, 0, 0x70, 0x20}; X and Y read 0.
- Strobe handling: `nwr` held low for 20 cycles → exactly one push. A read of address 9 → `data_out` = 0xFF, and `data_oe` deasserts within 3 cycles of `nrd` rising.
- Reset mid-transfer: assert `reset` while the FIFO holds 3 entries → `cmd_tvalid` = 0 and all outputs at their reset values on the next edge.
